ftdi_rx_deframer: RTL and testbench

Byte-stream deframer directly downstream of the FTDI synchronous-FIFO read controller. Accepts the raw bytes read from the FT2232H at 60 MHz and hunts for frames of the form SYNC(0xA5), LEN, CMD, LEN payload bytes, CHK. Emits payload bytes on a valid/ready stream with first/last markers, plus a per-frame good/bad status pulse. Backpressure on its input lets the read controller stall RDn when the consumer is slow.

---
 rtl/usb_rabbit_pkg.sv | 20 ++
 rtl/ftdi_rx_deframer.sv | 139 +++++++++++++
 tb/tb_ftdi_rx_deframer.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_rabbit_pkg.sv
// Shared constants for the FTDI receive path: sync byte, deframer state
// encoding and the frame error codes reported alongside frame_err_o.
package usb_rabbit_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_HUNT    = 3'd0,
        ST_LEN     = 3'd1,
        ST_CMD     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CHK     = 3'd4
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_LEN     = 2'b01;
    localparam logic [1:0] ERR_CHK     = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

endpackage

// File: rtl/ftdi_rx_deframer.sv
// Frame hunter for the CLK60 byte stream from the FTDI FIFO reader:
// SYNC, LEN, CMD, LEN payload bytes, XOR checksum; payload out on valid/ready.
//
// state   | meaning
// --------+-----------------------------------------------------------
// HUNT    | dropping bytes until SYNC_BYTE
// LEN     | next byte is the payload length (0 aborts the frame)
// CMD     | next byte is the command code
// PAYLOAD | forwarding payload bytes to the output register
// CHK     | next byte is compared against the running XOR
module ftdi_rx_deframer
    import usb_rabbit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 60000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_valid_i,
    input  logic [7:0] rx_data_i,
    output logic       rx_ready_o,
    output logic       out_valid_o,
    output logic [7:0] out_data_o,
    output logic       out_first_o,
    output logic       out_last_o,
    input  logic       out_ready_i,
    output logic [7:0] cmd_o,
    output logic [7:0] len_o,
    output logic       frame_ok_o,
    output logic       frame_err_o,
    output logic [1:0] err_code_o,
    output logic       busy_o
);

    localparam int              TW         = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]   IDLE_LIMIT = TW'(TIMEOUT_CYCLES - 1);

    state_t        state;
    logic [7:0]    chk;
    logic [7:0]    remaining;
    logic [TW-1:0] idle_cnt;

    logic rx_fire;
    logic out_fire;
    logic idle_expired;

    // Only the payload phase can be blocked, and only by a stalled output byte.
    assign rx_ready_o   = (state != ST_PAYLOAD) || !out_valid_o || out_ready_i;
    assign rx_fire      = rx_valid_i && rx_ready_o;
    assign out_fire     = out_valid_o && out_ready_i;
    assign idle_expired = (state != ST_HUNT) && (idle_cnt == IDLE_LIMIT);
    assign busy_o       = (state != ST_HUNT);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_HUNT;
            chk         <= '0;
            remaining   <= '0;
            idle_cnt    <= '0;
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_first_o <= 1'b0;
            out_last_o  <= 1'b0;
            cmd_o       <= '0;
            len_o       <= '0;
            frame_ok_o  <= 1'b0;
            frame_err_o <= 1'b0;
            err_code_o  <= ERR_NONE;
        end else begin
            frame_ok_o  <= 1'b0;
            frame_err_o <= 1'b0;

            if (out_fire) begin
                out_valid_o <= 1'b0;
                out_first_o <= 1'b0;
                out_last_o  <= 1'b0;
            end

            if (rx_fire || (state == ST_HUNT)) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end

            // An accepted byte takes priority over an expiring idle count.
            if (rx_fire) begin
                case (state)
                    ST_HUNT: begin
                        if (rx_data_i == SYNC_BYTE) begin
                            state <= ST_LEN;
                        end
                    end
                    ST_LEN: begin
                        len_o <= rx_data_i;
                        if (rx_data_i == 8'd0) begin
                            frame_err_o <= 1'b1;
                            err_code_o  <= ERR_LEN;
                            state       <= ST_HUNT;
                        end else begin
                            chk   <= rx_data_i;
                            state <= ST_CMD;
                        end
                    end
                    ST_CMD: begin
                        cmd_o     <= rx_data_i;
                        chk       <= chk ^ rx_data_i;
                        remaining <= len_o;
                        state     <= ST_PAYLOAD;
                    end
                    ST_PAYLOAD: begin
                        out_valid_o <= 1'b1;
                        out_data_o  <= rx_data_i;
                        out_first_o <= (remaining == len_o);
                        out_last_o  <= (remaining == 8'd1);
                        chk         <= chk ^ rx_data_i;
                        remaining   <= remaining - 8'd1;
                        if (remaining == 8'd1) begin
                            state <= ST_CHK;
                        end
                    end
                    ST_CHK: begin
                        if (rx_data_i == chk) begin
                            frame_ok_o <= 1'b1;
                        end else begin
                            frame_err_o <= 1'b1;
                            err_code_o  <= ERR_CHK;
                        end
                        state <= ST_HUNT;
                    end
                    default: state <= ST_HUNT;
                endcase
            end else if (idle_expired) begin
                frame_err_o <= 1'b1;
                err_code_o  <= ERR_TIMEOUT;
                state       <= ST_HUNT;
            end
        end
    end

endmodule

// File: tb/tb_ftdi_rx_deframer.sv
// Directed and randomized frames against ftdi_rx_deframer; expectations come
// from the bytes the bench itself sends (length, XOR checksum, idle gaps).
module tb_ftdi_rx_deframer;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       rx_valid_i;
    logic [7:0] rx_data_i;
    logic       rx_ready_o;
    logic       out_valid_o;
    logic [7:0] out_data_o;
    logic       out_first_o;
    logic       out_last_o;
    logic       out_ready_i;
    logic [7:0] cmd_o;
    logic [7:0] len_o;
    logic       frame_ok_o;
    logic       frame_err_o;
    logic [1:0] err_code_o;
    logic       busy_o;

    ftdi_rx_deframer #(.TIMEOUT_CYCLES(16)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rx_valid_i  (rx_valid_i),
        .rx_data_i   (rx_data_i),
        .rx_ready_o  (rx_ready_o),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .out_first_o (out_first_o),
        .out_last_o  (out_last_o),
        .out_ready_i (out_ready_i),
        .cmd_o       (cmd_o),
        .len_o       (len_o),
        .frame_ok_o  (frame_ok_o),
        .frame_err_o (frame_err_o),
        .err_code_o  (err_code_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [7:0] d;
        logic       f;
        logic       l;
        int         c;
    } obyte_t;

    obyte_t     got[$];
    int         tests = 0;
    int         failed = 0;
    int         cyc = 0;
    int         ok_cnt, err_cnt, both_cnt, rdy_low;
    logic [1:0] err_code_seen;
    int         err_cyc, acc_cyc;
    int         rdy_mode, stall_run;
    bit         last_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: pick out_ready, observe pre-edge transfers, observe pulses after the edge.
    task automatic step();
        obyte_t o;
        case (rdy_mode)
            0: out_ready_i = 1'b1;
            1: out_ready_i = (stall_run >= 3) ? 1'b1 : 1'($urandom_range(1, 0));
            2: out_ready_i = !out_ready_i;
            default: out_ready_i = 1'b0;
        endcase
        if (!out_ready_i) stall_run++;
        else stall_run = 0;
        #2;
        last_in = rx_valid_i && rx_ready_o;
        if (!rx_ready_o) rdy_low++;
        if (out_valid_o && out_ready_i) begin
            o.d = out_data_o;
            o.f = out_first_o;
            o.l = out_last_o;
            o.c = cyc;
            got.push_back(o);
        end
        @(posedge clk_i);
        #1;
        cyc++;
        if (last_in) acc_cyc = cyc;
        if (frame_ok_o) ok_cnt++;
        if (frame_err_o) begin
            err_cnt++;
            err_code_seen = err_code_o;
            err_cyc = cyc;
        end
        if (frame_ok_o && frame_err_o) both_cnt++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid_i = 1'b1;
        rx_data_i  = b;
        last_in    = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (last_in) break;
        end
        check("rx_accept", 32'(last_in), 32'd1);
        rx_valid_i = 1'b0;
    endtask

    task automatic clear_obs();
        got.delete();
        ok_cnt   = 0;
        err_cnt  = 0;
        both_cnt = 0;
        rdy_low  = 0;
        err_code_seen = 2'b00;
    endtask

    task automatic drain();
        int saved;
        saved    = rdy_mode;
        rdy_mode = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (i >= 1 && !out_valid_o) break;
        end
        rdy_mode = saved;
    endtask

    // Sends one frame (optionally preceded by garbage) and checks everything it should produce.
    task automatic run_frame(input string tag, input logic [7:0] len, input logic [7:0] cmd,
                             input logic [7:0] pl[$], input logic [7:0] chk,
                             input int gap_lo, input int gap_hi, input bit garbage);
        logic [7:0] bytes[$];
        logic [7:0] exp_chk;
        logic [7:0] g;
        int         n;
        clear_obs();
        if (garbage) begin
            n = $urandom_range(3, 0);
            for (int i = 0; i < n; i++) begin
                g = 8'($urandom_range(255, 0));
                if (g == 8'hA5) g = 8'h5A;
                send_byte(g);
            end
        end
        bytes.push_back(8'hA5);
        bytes.push_back(len);
        if (len != 8'd0) begin
            bytes.push_back(cmd);
            foreach (pl[i]) bytes.push_back(pl[i]);
            bytes.push_back(chk);
        end
        foreach (bytes[i]) begin
            send_byte(bytes[i]);
            if (i != bytes.size() - 1) idle($urandom_range(gap_hi, gap_lo));
        end
        drain();

        exp_chk = len ^ cmd;
        foreach (pl[i]) exp_chk ^= pl[i];
        check({tag, "_len_o"}, 32'(len_o), 32'(len));
        check({tag, "_both"}, 32'(both_cnt), 32'd0);
        check({tag, "_busy"}, 32'(busy_o), 32'd0);
        if (len == 8'd0) begin
            check({tag, "_nbytes"}, 32'(got.size()), 32'd0);
            check({tag, "_ok"}, 32'(ok_cnt), 32'd0);
            check({tag, "_err"}, 32'(err_cnt), 32'd1);
            check({tag, "_code"}, 32'(err_code_seen), 32'd1);
        end else begin
            check({tag, "_cmd_o"}, 32'(cmd_o), 32'(cmd));
            check({tag, "_nbytes"}, 32'(got.size()), 32'(len));
            for (int i = 0; i < got.size() && i < pl.size(); i++) begin
                check({tag, "_data"}, 32'(got[i].d), 32'(pl[i]));
                check({tag, "_first"}, 32'(got[i].f), 32'(i == 0));
                check({tag, "_last"}, 32'(got[i].l), 32'(i == pl.size() - 1));
            end
            if (chk == exp_chk) begin
                check({tag, "_ok"}, 32'(ok_cnt), 32'd1);
                check({tag, "_err"}, 32'(err_cnt), 32'd0);
            end else begin
                check({tag, "_ok"}, 32'(ok_cnt), 32'd0);
                check({tag, "_err"}, 32'(err_cnt), 32'd1);
                check({tag, "_code"}, 32'(err_code_seen), 32'd2);
            end
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, observed running, expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pl[$];
        logic [7:0] len, cmd, chk, x;
        int         t0;

        rst_i = 1'b1; rx_valid_i = 1'b0; rx_data_i = 8'h00; out_ready_i = 1'b1;
        rdy_mode = 0; stall_run = 0;
        clear_obs();

        // Reset state
        idle(2);
        check("rst_out_valid", 32'(out_valid_o), 32'd0);
        check("rst_out_first", 32'(out_first_o), 32'd0);
        check("rst_out_last", 32'(out_last_o), 32'd0);
        check("rst_out_data", 32'(out_data_o), 32'd0);
        check("rst_cmd", 32'(cmd_o), 32'd0);
        check("rst_len", 32'(len_o), 32'd0);
        check("rst_ok", 32'(frame_ok_o), 32'd0);
        check("rst_err", 32'(frame_err_o), 32'd0);
        check("rst_code", 32'(err_code_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_rx_ready", 32'(rx_ready_o), 32'd1);
        rst_i = 1'b0;
        idle(1);

        // Basic frame at full throughput
        pl = '{8'h11, 8'h22, 8'h33};
        run_frame("basic", 8'h03, 8'h10, pl, 8'h13, 0, 0, 1'b0);
        if (got.size() == 3) check("basic_throughput", 32'(got[2].c - got[0].c), 32'd2);

        // Bad checksum still emits payload
        run_frame("badchk", 8'h03, 8'h10, pl, 8'h14, 0, 0, 1'b0);

        // Garbage dropped, then LEN=0
        clear_obs();
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
        check("garbage_busy", 32'(busy_o), 32'd0);
        check("garbage_err", 32'(err_cnt), 32'd0);
        run_frame("len0", 8'h00, 8'h00, pl, 8'h00, 0, 0, 1'b0);

        // Timeout 16 cycles after the last accepted byte
        clear_obs();
        rdy_mode = 0;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h20); send_byte(8'h01);
        t0 = acc_cyc;
        for (int i = 0; i < 40 && err_cnt == 0; i++) step();
        check("to_err", 32'(err_cnt), 32'd1);
        check("to_code", 32'(err_code_seen), 32'd3);
        check("to_latency", 32'(err_cyc - t0), 32'd16);
        check("to_busy", 32'(busy_o), 32'd0);
        check("to_payload_n", 32'(got.size()), 32'd1);
        step();
        check("to_pulse_width", 32'(frame_err_o), 32'd0);
        pl = '{8'h7E, 8'hA5};
        run_frame("after_to", 8'h02, 8'h21, pl, 8'h02 ^ 8'h21 ^ 8'h7E ^ 8'hA5, 0, 0, 1'b0);

        // Byte arriving exactly at the limit wins: 15 idle cycles between every byte
        pl = '{8'h01, 8'h02, 8'h03};
        run_frame("gap15", 8'h03, 8'h40, pl, 8'h03 ^ 8'h40 ^ 8'h01 ^ 8'h02 ^ 8'h03, 15, 15, 1'b0);

        // Output stalled every other cycle
        rdy_mode = 2;
        pl = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        run_frame("toggle", 8'h04, 8'h55, pl, 8'h04 ^ 8'h55 ^ 8'hC1 ^ 8'hC2 ^ 8'hC3 ^ 8'hC4, 0, 0, 1'b0);
        check("toggle_rx_ready_drop", 32'(rdy_low > 0), 32'd1);

        // Reset mid-payload with a byte pending on the output
        clear_obs();
        rdy_mode = 3;
        send_byte(8'hA5); send_byte(8'h05); send_byte(8'h30); send_byte(8'hB1);
        check("midrst_pending", 32'(out_valid_o), 32'd1);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check("midrst_out_valid", 32'(out_valid_o), 32'd0);
        check("midrst_out_data", 32'(out_data_o), 32'd0);
        check("midrst_cmd", 32'(cmd_o), 32'd0);
        check("midrst_len", 32'(len_o), 32'd0);
        check("midrst_busy", 32'(busy_o), 32'd0);
        check("midrst_status", 32'(ok_cnt + err_cnt), 32'd0);
        check("midrst_rx_ready", 32'(rx_ready_o), 32'd1);
        rdy_mode = 1;
        pl = '{8'hD0, 8'hD1};
        run_frame("after_rst", 8'h02, 8'h31, pl, 8'h02 ^ 8'h31 ^ 8'hD0 ^ 8'hD1, 0, 1, 1'b0);

        // Longest interesting length: LEN equal to the sync byte
        pl.delete();
        for (int i = 0; i < 165; i++) pl.push_back(8'($urandom_range(255, 0)));
        chk = 8'hA5 ^ 8'h66;
        foreach (pl[i]) chk ^= pl[i];
        run_frame("len_a5", 8'hA5, 8'h66, pl, chk, 0, 1, 1'b0);

        // Randomized frames
        for (int f = 0; f < 40; f++) begin
            len = ($urandom_range(9, 0) == 0) ? 8'd0 : 8'($urandom_range(8, 1));
            cmd = 8'($urandom_range(255, 0));
            pl.delete();
            for (int i = 0; i < int'(len); i++) pl.push_back(8'($urandom_range(255, 0)));
            chk = len ^ cmd;
            foreach (pl[i]) chk ^= pl[i];
            if ($urandom_range(3, 0) == 0) begin
                x = 8'($urandom_range(255, 1));
                chk ^= x;
            end
            run_frame("rand", len, cmd, pl, chk, 0, 2, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
